// File: rtl/subbytes_scheduler_if.sv
// subbytes_scheduler_if
//   Groups the two requester paths of subbytes_scheduler into one bundle.
//   State path : st_req/st_inv/st_data in, st_ack/st_done/st_result out.
//   Key path   : kw_req/kw_data in, kw_ack/kw_done/kw_result out.
//   busy       : scheduler is running a substitution.
//   Modports: master = requester side, slave = scheduler side.
interface subbytes_scheduler_if;
  logic         st_req;
  logic         st_inv;
  logic [127:0] st_data;
  logic         st_ack;
  logic         st_done;
  logic [127:0] st_result;
  logic         kw_req;
  logic [31:0]  kw_data;
  logic         kw_ack;
  logic         kw_done;
  logic [31:0]  kw_result;
  logic         busy;

  modport master (
    output st_req, st_inv, st_data, kw_req, kw_data,
    input  st_ack, st_done, st_result, kw_ack, kw_done, kw_result, busy
  );

  modport slave (
    input  st_req, st_inv, st_data, kw_req, kw_data,
    output st_ack, st_done, st_result, kw_ack, kw_done, kw_result, busy
  );
endinterface

// File: rtl/subbytes_scheduler.sv
// subbytes_scheduler
//   Shares LANES AES S-box lanes between a 128-bit round-state SubBytes
//   requester and a 32-bit key-expansion SubWord requester. Round-robin
//   arbitration in IDLE, then one chunk of LANES bytes is substituted per
//   cycle in a work register; done/result follow the last chunk.
// Parameters: LANES = 1, 2, 4, 8 or 16 shared lanes.
// Ports: clk, rst (synchronous, active-high), bus (subbytes_scheduler_if.slave).
// Build option: define SBOX_INV_EN to compile inverse S-box lanes; st_inv
//   then selects inverse substitution on the state path. Without it st_inv
//   is ignored and both paths use forward substitution.
module subbytes_scheduler #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  subbytes_scheduler_if.slave  bus
);

  localparam int K_ST = 16 / LANES;
  localparam int K_KW = (LANES >= 4) ? 1 : (4 / LANES);
  localparam logic [3:0] LAST_ST = 4'(K_ST - 1);
  localparam logic [3:0] LAST_KW = 4'(K_KW - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN_ST = 2'd1;
  localparam logic [1:0] RUN_KW = 2'd2;

  // GF(2^8) arithmetic, AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^-1 for x != 0, and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

`ifdef SBOX_INV_EN
  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] b;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction
`endif

  logic [1:0]   state_reg;
  logic [3:0]   cnt_reg;
  logic         last_st_reg;   // 1: state path granted last, key wins a tie
  logic         st_done_reg;
  logic         kw_done_reg;
  logic [127:0] st_result_reg;
  logic [31:0]  kw_result_reg;
  logic [7:0]   work_reg  [16]; // byte 0 = most significant byte
  logic [7:0]   work_next [16];
  logic [127:0] work_next_flat;
`ifdef SBOX_INV_EN
  logic         inv_reg;
`endif

  logic idle;
  logic grant_st;
  logic grant_kw;
  logic last_chunk;

  logic [3:0] lane_idx [LANES];
  logic [7:0] lane_out [LANES];
  logic       lane_we  [LANES];

  assign idle     = (state_reg == IDLE);
  assign grant_st = !rst && idle && bus.st_req && (!bus.kw_req || !last_st_reg);
  assign grant_kw = !rst && idle && bus.kw_req && (!bus.st_req ||  last_st_reg);
  assign last_chunk = ((state_reg == RUN_ST) && (cnt_reg == LAST_ST)) ||
                      ((state_reg == RUN_KW) && (cnt_reg == LAST_KW));

  assign bus.st_ack    = grant_st;
  assign bus.kw_ack    = grant_kw;
  assign bus.st_done   = st_done_reg;
  assign bus.kw_done   = kw_done_reg;
  assign bus.st_result = st_result_reg;
  assign bus.kw_result = kw_result_reg;
  assign bus.busy      = !idle;

  // Each lane substitutes byte cnt*LANES+gi of the work register.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] lane_in;
      assign lane_idx[gi] = 4'(int'(cnt_reg) * LANES + gi);
      assign lane_in      = work_reg[lane_idx[gi]];
`ifdef SBOX_INV_EN
      assign lane_out[gi] = inv_reg ? sbox_inv(lane_in) : sbox_fwd(lane_in);
`else
      assign lane_out[gi] = sbox_fwd(lane_in);
`endif
      // Key word lives in bytes 0..3; wider configurations leave the rest alone
      assign lane_we[gi]  = (state_reg == RUN_ST) ||
                            ((state_reg == RUN_KW) && (lane_idx[gi] < 4'd4));
    end
    for (genvar gi = 0; gi < 16; gi++) begin : g_flat
      assign work_next_flat[127 - 8*gi -: 8] = work_next[gi];
    end
  endgenerate

  always_comb begin
    for (int b = 0; b < 16; b++) work_next[b] = work_reg[b];
    for (int l = 0; l < LANES; l++) begin
      if (lane_we[l]) work_next[lane_idx[l]] = lane_out[l];
    end
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      last_st_reg   <= 1'b1;
      st_done_reg   <= 1'b0;
      kw_done_reg   <= 1'b0;
      st_result_reg <= '0;
      kw_result_reg <= '0;
    end else begin
      st_done_reg <= 1'b0;
      kw_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_st) begin
            state_reg   <= RUN_ST;
            last_st_reg <= 1'b1;
          end else if (grant_kw) begin
            state_reg   <= RUN_KW;
            last_st_reg <= 1'b0;
          end
        end
        RUN_ST, RUN_KW: begin
          if (last_chunk) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            if (state_reg == RUN_ST) begin
              st_done_reg   <= 1'b1;
              st_result_reg <= work_next_flat;
            end else begin
              kw_done_reg   <= 1'b1;
              kw_result_reg <= work_next_flat[127:96];
            end
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Work register: loaded on ack, updated in place while running
  always_ff @(posedge clk) begin
    if (grant_st) begin
      for (int b = 0; b < 16; b++) work_reg[b] <= bus.st_data[127 - 8*b -: 8];
`ifdef SBOX_INV_EN
      inv_reg <= bus.st_inv;
`endif
    end else if (grant_kw) begin
      for (int b = 0; b < 4; b++) work_reg[b] <= bus.kw_data[31 - 8*b -: 8];
`ifdef SBOX_INV_EN
      inv_reg <= 1'b0;
`endif
    end else if (!idle) begin
      for (int b = 0; b < 16; b++) work_reg[b] <= work_next[b];
    end
  end

endmodule

// File: tb/tb_subbytes_scheduler.sv
// tb_subbytes_scheduler
//   Directed bench for subbytes_scheduler: LANES=4 main instance plus
//   LANES=1 and LANES=16 instances for chunk-count timing.
module tb_subbytes_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  subbytes_scheduler_if bus ();
  subbytes_scheduler_if bus1 ();
  subbytes_scheduler_if bus16 ();

  subbytes_scheduler #(.LANES(4))  u_dut     (.clk(clk), .rst(rst), .bus(bus));
  subbytes_scheduler #(.LANES(1))  u_dut_l1  (.clk(clk), .rst(rst), .bus(bus1));
  subbytes_scheduler #(.LANES(16)) u_dut_l16 (.clk(clk), .rst(rst), .bus(bus16));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Called at a negedge with the request already driven.
  task automatic wait_ack(input int which, output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((which == 0 && bus.st_ack) || (which == 1 && bus.kw_ack)) begin
        c = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int which, output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((which == 0 && bus.st_done) || (which == 1 && bus.kw_done)) begin
        c = cyc;
        $display("txn %s done at cycle %0d st_result=%h kw_result=%h",
                 (which == 0) ? "st" : "kw", cyc, bus.st_result, bus.kw_result);
        break;
      end
    end
  endtask

  logic [127:0] exp_inv63;
  logic [127:0] exp_inved;

  initial begin
    int t;
    int d;
    int d1;
    int d16;

`ifdef SBOX_INV_EN
    exp_inv63 = '0;
    exp_inved = {16{8'h53}};
`else
    exp_inv63 = {16{8'hfb}};
    exp_inved = {16{8'h55}};
`endif

    rst = 1'b1;
    bus.st_req = 0;   bus.st_inv = 0;   bus.st_data = '0;   bus.kw_req = 0;   bus.kw_data = '0;
    bus1.st_req = 0;  bus1.st_inv = 0;  bus1.st_data = '0;  bus1.kw_req = 0;  bus1.kw_data = '0;
    bus16.st_req = 0; bus16.st_inv = 0; bus16.st_data = '0; bus16.kw_req = 0; bus16.kw_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_flags", {bus.st_ack, bus.kw_ack, bus.st_done, bus.kw_done}, 4'b0);
    check("rst_st_result", bus.st_result, 0);
    check("rst_kw_result", bus.kw_result, 0);
    rst = 1'b0;

    // First tie after reset: key path wins
    @(negedge clk);
    bus.st_req = 1; bus.st_data = '0; bus.st_inv = 0;
    bus.kw_req = 1; bus.kw_data = 32'hcf4f3c09;
    #1;
    check("tie1_ack", {bus.st_ack, bus.kw_ack}, 2'b01);
    t = cyc;
    @(negedge clk);
    bus.kw_req = 0;
    #1;
    check("tie1_busy", bus.busy, 1);
    check("tie1_st_waits", bus.st_ack, 0);
    @(negedge clk);
    #1;
    check("kw_done_t2", {bus.kw_done, 32'(cyc - t)}, {1'b1, 32'd2});
    check("kw_result_cf4f", bus.kw_result, 32'h8a84eb01);
    check("st_ack_at_kw_done", bus.st_ack, 1);
    check("st_result_untouched", bus.st_result, 0);
    t = cyc;
    @(negedge clk);
    bus.st_req = 0;
    wait_done(0, d);
    check("st_done_t5", d, t + 5);
    check("st_result_zero", bus.st_result, {16{8'h63}});
    check("kw_result_kept", bus.kw_result, 32'h8a84eb01);

    // Second tie: state was granted last, so key wins again
    bus.st_req = 1; bus.st_data = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    bus.kw_req = 1; bus.kw_data = 32'h53535353;
    #1;
    check("tie2_ack", {bus.st_ack, bus.kw_ack}, 2'b01);
    @(negedge clk);
    bus.kw_req = 0;
    @(negedge clk);
    #1;
    check("kw_done_53", bus.kw_done, 1);
    check("kw_result_ed", bus.kw_result, 32'hedededed);
    check("st_result_kept", bus.st_result, {16{8'h63}});
    check("st_ack_b2b", bus.st_ack, 1);
    t = cyc;
    @(negedge clk);
    bus.st_req = 0;
    wait_done(0, d);
    check("st_done_fips_t5", d, t + 5);
    check("st_result_fips", bus.st_result, 128'hd42711aee0bf98f1b8b45de51e415230);

    // Back-to-back state request with st_inv=1
    bus.st_req = 1; bus.st_inv = 1; bus.st_data = {16{8'h63}};
    #1;
    check("st_ack_same_as_done", bus.st_ack, 1);
    t = cyc;
    @(negedge clk);
    bus.st_req = 0; bus.st_inv = 0;
    wait_done(0, d);
    check("inv63_t5", d, t + 5);
    check("inv63_result", bus.st_result, exp_inv63);
    @(negedge clk);
    bus.st_req = 1; bus.st_inv = 1; bus.st_data = {16{8'hed}};
    wait_ack(0, t);
    @(negedge clk);
    bus.st_req = 0; bus.st_inv = 0;
    wait_done(0, d);
    check("inved_t5", d, t + 5);
    check("inved_result", bus.st_result, exp_inved);

    // Reset in the middle of a state run, request held
    @(negedge clk);
    bus.st_req = 1; bus.st_data = '0;
    wait_ack(0, t);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_flags", {bus.st_ack, bus.kw_ack, bus.st_done, bus.kw_done}, 4'b0);
    check("midrst_st_result", bus.st_result, 0);
    check("midrst_kw_result", bus.kw_result, 0);
    rst = 1'b0;
    wait_ack(0, t);
    check("midrst_reack_seen", (t >= 0), 1);
    @(negedge clk);
    bus.st_req = 0;
    bus.kw_req = 1; bus.kw_data = 32'hcf4f3c09;
    #1;
    check("kw_waits_busy", bus.kw_ack, 0);
    wait_done(0, d);
    check("reack_done_t5", d, t + 5);
    check("reack_result", bus.st_result, {16{8'h63}});
    #1;
    check("kw_ack_at_st_done", bus.kw_ack, 1);
    t = cyc;
    @(negedge clk);
    bus.kw_req = 0;
    wait_done(1, d);
    check("kw_after_wait_t2", d, t + 2);
    check("kw_after_wait_result", bus.kw_result, 32'h8a84eb01);

    // LANES=1 and LANES=16 state path
    @(negedge clk);
    bus1.st_req = 1; bus16.st_req = 1;
    #1;
    check("sweep_st_ack", {bus1.st_ack, bus16.st_ack}, 2'b11);
    t = cyc;
    @(negedge clk);
    bus1.st_req = 0; bus16.st_req = 0;
    d1 = -1; d16 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (d1 < 0 && bus1.st_done) d1 = cyc;
      if (d16 < 0 && bus16.st_done) d16 = cyc;
    end
    $display("txn sweep st: lanes1 done %0d lanes16 done %0d", d1, d16);
    check("l1_st_t17", d1, t + 17);
    check("l16_st_t2", d16, t + 2);
    check("l1_st_result", bus1.st_result, {16{8'h63}});
    check("l16_st_result", bus16.st_result, {16{8'h63}});

    // LANES=1 and LANES=16 key path
    bus1.kw_req = 1; bus1.kw_data = 32'hcf4f3c09;
    bus16.kw_req = 1; bus16.kw_data = 32'hcf4f3c09;
    #1;
    check("sweep_kw_ack", {bus1.kw_ack, bus16.kw_ack}, 2'b11);
    t = cyc;
    @(negedge clk);
    bus1.kw_req = 0; bus16.kw_req = 0;
    d1 = -1; d16 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d1 < 0 && bus1.kw_done) d1 = cyc;
      if (d16 < 0 && bus16.kw_done) d16 = cyc;
    end
    $display("txn sweep kw: lanes1 done %0d lanes16 done %0d", d1, d16);
    check("l1_kw_t5", d1, t + 5);
    check("l16_kw_t2", d16, t + 2);
    check("l1_kw_result", bus1.kw_result, 32'h8a84eb01);
    check("l16_kw_result", bus16.kw_result, 32'h8a84eb01);
    check("l16_st_result_kept", bus16.st_result, {16{8'h63}});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/subbytes_scheduler.md
SUBBYTES_SCHEDULER -- requirements
Module: subbytes_scheduler

Interface
REQ-001 SHALL have parameter LANES, default 4, number of shared S-box lanes; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports st_req input 1, st_inv input 1, st_data input 128: round-state SubBytes request, direction, and data.
REQ-005 SHALL have ports st_ack output 1, st_done output 1, st_result output 128: state-path accept pulse, completion pulse, and result.
REQ-006 SHALL have ports kw_req input 1, kw_data input 32: key-expansion SubWord request and data.
REQ-007 SHALL have ports kw_ack output 1, kw_done output 1, kw_result output 32: key-path accept pulse, completion pulse, and result.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, RUN_ST, RUN_KW.
REQ-010 Requester handshake: hold req high with data stable until ack.
  - ack is a one-cycle pulse, asserted only in IDLE.
  - data and st_inv are captured into a work register in the ack cycle.
REQ-011 Arbitration: round-robin with a last-granted pointer.
  - Both requests high in IDLE: grant goes to the requester not last granted.
  - After reset, kw wins the first tie.
REQ-012 Byte numbering: byte 0 = most significant byte ([127:120] or [31:24]); chunk i covers bytes i*LANES .. i*LANES+LANES-1.
REQ-013 Chunk count: K = 16/LANES for state; K = max(1, 4/LANES) for key; with LANES>4, key uses only lanes 0-3.
REQ-014 Timing for an ack in cycle T:
  - RUN cycles T+1 .. T+K each substitute one chunk in place in the work register.
  - In T+K+1: done pulses high, result output is updated, FSM is back in IDLE.
REQ-015 A new ack may occur in the same cycle as the previous done (back-to-back, no bubble).
REQ-016 result SHALL hold its value until that requester's next done; the other requester's result SHALL be unaffected.
REQ-017 Requests that arrive while busy SHALL wait; no ack, no data capture.
REQ-018 The chunk counter SHALL wrap to 0 on completion; it is never read beyond K-1.
REQ-019 Key path SHALL always use forward substitution.
REQ-020 Substitution SHALL be the FIPS-197 forward/inverse S-box, computed combinationally per lane.

Reset
REQ-021 rst high on any edge SHALL force the following, regardless of the state it interrupts:
  - state IDLE, counter 0, pointer to kw-first;
  - all outputs to 0 (ack, done, busy, st_result, kw_result).
REQ-022 Reset during RUN SHALL abandon the operation with no done; a request still held after reset SHALL be re-arbitrated.

Configuration
REQ-023 Macro SBOX_INV_EN defined: inverse S-box lanes are compiled in; st_inv=1 selects inverse substitution for the state path.
REQ-024 Macro SBOX_INV_EN undefined: inverse lanes are absent; st_inv is ignored; the state path always uses forward substitution.

Verification
REQ-025 LANES=4, st_data all 0x00, st_inv=0, ack at T -> st_done at T+5, st_result = 0x63 repeated 16 times.
REQ-026 kw_data 32'hcf4f3c09 -> kw_done at T+2, kw_result 32'h8a84eb01; st_result unchanged.
REQ-027 st_req and kw_req both rise together after reset:
  - kw_ack first; st_ack coincides with kw_done.
  - Next tie after that: kw granted (st was last granted).
REQ-028 With SBOX_INV_EN, st_inv=1, data 0x63 repeated 16 times -> result all 0x00; byte 0x53 forward -> 0xed, inverse of 0xed -> 0x53.
REQ-029 rst asserted at T+2 of a state run -> next cycle all outputs 0 and busy=0, no st_done; held st_req re-acked.
REQ-030 Sweep LANES=1,16: state done at T+17 and T+2 respectively, same results as REQ-025.
